// File: rtl/dcache_port_arbiter_pkg.sv
// Shared types and defaults for the data-cache port arbiter.
package dcache_port_arbiter_pkg;

    localparam int ADDR_W_DEF          = 32;
    localparam int DATA_W_DEF          = 32;
    localparam int MAX_LOAD_STREAK_DEF = 4;
    localparam int STREAK_W            = 8;   // holds MAX_LOAD_STREAK up to 255

    typedef logic [ADDR_W_DEF-1:0] address_t;
    typedef logic [DATA_W_DEF-1:0] data_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD_BUSY,
        STORE_BUSY,
        LOAD_SQUASH
    } arb_state_t;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } mem_action_t;

endpackage

// File: rtl/dcache_port_arbiter_streak_counter.sv
// Saturating count of consecutive load grants taken while a store was waiting.
module arb_streak_counter
    import dcache_port_arbiter_pkg::*;
#(
    parameter int MAX = MAX_LOAD_STREAK_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam logic [STREAK_W-1:0] MAX_CNT = STREAK_W'(MAX);

    logic [STREAK_W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments and resets asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !sat) begin
            count <= count + 1'b1;
        end
    end

    assign sat = (count == MAX_CNT);

endmodule

// File: rtl/dcache_port_arbiter.sv
// Arbitrates the single data-cache port between loads and store-queue drain.
// Optional perf counters are enabled with `define DCACHE_ARB_PERF_EN.
module dcache_port_arbiter
    import dcache_port_arbiter_pkg::*;
#(
    parameter int ADDR_W          = ADDR_W_DEF,
    parameter int DATA_W          = DATA_W_DEF,
    parameter int MAX_LOAD_STREAK = MAX_LOAD_STREAK_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_flush,
    input  logic              i_load_valid,
    input  logic [ADDR_W-1:0] i_load_addr,
    output logic              o_load_grant,
    output logic              o_load_resp_valid,
    output logic [DATA_W-1:0] o_load_resp_data,
    input  logic              i_store_valid,
    input  logic [ADDR_W-1:0] i_store_addr,
    input  logic [DATA_W-1:0] i_store_data,
    output logic              o_store_done,
    output logic              o_mem_valid,
    output logic              o_mem_action,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_data,
    input  logic              i_mem_resp_valid,
    input  logic [DATA_W-1:0] i_mem_resp_data,
    output logic              o_busy
`ifdef DCACHE_ARB_PERF_EN
    ,
    output logic [31:0]       o_perf_load_cnt,
    output logic [31:0]       o_perf_store_cnt,
    output logic [31:0]       o_perf_store_wait_cnt
`endif
);

    arb_state_t state;
    logic       armed;        // low until the first edge after reset, keeps the grant quiet
    logic       load_req;
    logic       load_grant;
    logic       store_grant;
    logic       streak_sat;
    logic       streak_inc;
    logic       streak_clr;

    arb_streak_counter #(.MAX(MAX_LOAD_STREAK)) u_streak (
        .clk (clk),
        .rst (rst),
        .inc (streak_inc),
        .clr (streak_clr),
        .sat (streak_sat)
    );

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        load_req    = i_load_valid && !i_flush;
        load_grant  = 1'b0;
        store_grant = 1'b0;
        if (state == IDLE && armed) begin
            if (i_store_valid && (!load_req || streak_sat)) begin
                store_grant = 1'b1;
            end else if (load_req) begin
                load_grant = 1'b1;
            end
        end
        streak_inc = load_grant && i_store_valid;
        streak_clr = store_grant || (load_grant && !i_store_valid);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            armed        <= 1'b0;
            o_mem_valid  <= 1'b0;
            o_mem_action <= READ;
            o_mem_addr   <= '0;
            o_mem_data   <= '0;
        end else begin
            armed <= 1'b1;
            case (state)
                IDLE: begin
                    if (store_grant) begin
                        state        <= STORE_BUSY;
                        o_mem_valid  <= 1'b1;
                        o_mem_action <= WRITE;
                        o_mem_addr   <= i_store_addr;
                        o_mem_data   <= i_store_data;
                    end else if (load_grant) begin
                        state        <= LOAD_BUSY;
                        o_mem_valid  <= 1'b1;
                        o_mem_action <= READ;
                        o_mem_addr   <= i_load_addr;
                        o_mem_data   <= '0;
                    end
                end
                LOAD_BUSY: begin
                    if (i_mem_resp_valid) begin
                        state       <= IDLE;
                        o_mem_valid <= 1'b0;
                    end else if (i_flush) begin
                        state <= LOAD_SQUASH;   // request stays on the port until the cache answers
                    end
                end
                STORE_BUSY, LOAD_SQUASH: begin
                    if (i_mem_resp_valid) begin
                        state       <= IDLE;
                        o_mem_valid <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    o_mem_valid <= 1'b0;
                end
            endcase
        end
    end

    // A flush in the response cycle still kills the load data.
    assign o_load_grant      = load_grant;
    assign o_load_resp_valid = (state == LOAD_BUSY) && i_mem_resp_valid && !i_flush;
    assign o_load_resp_data  = o_load_resp_valid ? i_mem_resp_data : '0;
    assign o_store_done      = (state == STORE_BUSY) && i_mem_resp_valid;
    assign o_busy            = (state != IDLE);

`ifdef DCACHE_ARB_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_perf_load_cnt       <= '0;
            o_perf_store_cnt      <= '0;
            o_perf_store_wait_cnt <= '0;
        end else begin
            if (load_grant)  o_perf_load_cnt  <= o_perf_load_cnt + 1'b1;
            if (store_grant) o_perf_store_cnt <= o_perf_store_cnt + 1'b1;
            if (i_store_valid && !store_grant && state != STORE_BUSY)
                o_perf_store_wait_cnt <= o_perf_store_wait_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Directed-vector bench for dcache_port_arbiter (default build, MAX_LOAD_STREAK=4).
module tb_dcache_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_flush;
    logic        i_load_valid;
    logic [31:0] i_load_addr;
    logic        o_load_grant;
    logic        o_load_resp_valid;
    logic [31:0] o_load_resp_data;
    logic        i_store_valid;
    logic [31:0] i_store_addr;
    logic [31:0] i_store_data;
    logic        o_store_done;
    logic        o_mem_valid;
    logic        o_mem_action;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_data;
    logic        i_mem_resp_valid;
    logic [31:0] i_mem_resp_data;
    logic        o_busy;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    dcache_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_LOAD_STREAK(4)) dut (
        .clk               (clk),
        .rst               (rst),
        .i_flush           (i_flush),
        .i_load_valid      (i_load_valid),
        .i_load_addr       (i_load_addr),
        .o_load_grant      (o_load_grant),
        .o_load_resp_valid (o_load_resp_valid),
        .o_load_resp_data  (o_load_resp_data),
        .i_store_valid     (i_store_valid),
        .i_store_addr      (i_store_addr),
        .i_store_data      (i_store_data),
        .o_store_done      (o_store_done),
        .o_mem_valid       (o_mem_valid),
        .o_mem_action      (o_mem_action),
        .o_mem_addr        (o_mem_addr),
        .o_mem_data        (o_mem_data),
        .i_mem_resp_valid  (i_mem_resp_valid),
        .i_mem_resp_data   (i_mem_resp_data),
        .o_busy            (o_busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are checked at the falling edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; i_flush = 1'b0;
        i_load_valid = 1'b1; i_load_addr = 32'h0;
        i_store_valid = 1'b0; i_store_addr = 32'h0; i_store_data = 32'h0;
        i_mem_resp_valid = 1'b0; i_mem_resp_data = 32'h0;

        // reset: all outputs quiet, even with a load request present
        #8;
        check("rst_grant", o_load_grant, 1'b0);
        check("rst_busy", o_busy, 1'b0);
        check("rst_mem_valid", o_mem_valid, 1'b0);
        check("rst_mem_addr", o_mem_addr, 32'h0);
        #1 rst = 1'b0;
        #1 check("post_rst_grant", o_load_grant, 1'b0);
        i_load_valid = 1'b0;
        cyc();

        // load only
        i_load_valid = 1'b1; i_load_addr = 32'h100;
        mid(); check("ld_grant", o_load_grant, 1'b1); check("ld_c0_mem_valid", o_mem_valid, 1'b0);
        cyc(); i_load_valid = 1'b0;
        mid(); check("ld_c1_mem_valid", o_mem_valid, 1'b1); check("ld_c1_action", o_mem_action, 1'b0);
        check("ld_c1_addr", o_mem_addr, 32'h100); check("ld_c1_busy", o_busy, 1'b1);
        cyc();
        mid(); check("ld_c2_mem_valid", o_mem_valid, 1'b1); check("ld_c2_resp", o_load_resp_valid, 1'b0);
        cyc(); i_mem_resp_valid = 1'b1; i_mem_resp_data = 32'hDEAD;
        mid(); check("ld_c3_resp", o_load_resp_valid, 1'b1); check("ld_c3_data", o_load_resp_data, 32'hDEAD);
        check("ld_c3_mem_valid", o_mem_valid, 1'b1);
        cyc(); i_mem_resp_valid = 1'b0;
        mid(); check("ld_c4_busy", o_busy, 1'b0); check("ld_c4_mem_valid", o_mem_valid, 1'b0);
        check("ld_c4_resp", o_load_resp_valid, 1'b0);
        cyc();

        // simultaneous load and store: load first, store at next IDLE
        i_load_valid = 1'b1; i_load_addr = 32'h300;
        i_store_valid = 1'b1; i_store_addr = 32'h200; i_store_data = 32'h7;
        mid(); check("sim_ld_grant", o_load_grant, 1'b1);
        cyc(); i_load_valid = 1'b0; i_mem_resp_valid = 1'b1; i_mem_resp_data = 32'h1234;
        mid(); check("sim_ld_addr", o_mem_addr, 32'h300); check("sim_ld_resp", o_load_resp_valid, 1'b1);
        check("sim_ld_data", o_load_resp_data, 32'h1234); check("sim_st_done_early", o_store_done, 1'b0);
        cyc(); i_mem_resp_valid = 1'b0;
        mid(); check("sim_bubble_busy", o_busy, 1'b0); check("sim_bubble_grant", o_load_grant, 1'b0);
        cyc(); i_mem_resp_valid = 1'b1; i_mem_resp_data = 32'h0;
        mid(); check("sim_st_mem_valid", o_mem_valid, 1'b1); check("sim_st_action", o_mem_action, 1'b1);
        check("sim_st_addr", o_mem_addr, 32'h200); check("sim_st_data", o_mem_data, 32'h7);
        check("sim_st_done", o_store_done, 1'b1); check("sim_st_no_ld_resp", o_load_resp_valid, 1'b0);
        cyc(); i_mem_resp_valid = 1'b0; i_store_valid = 1'b0;
        mid(); check("sim_end_busy", o_busy, 1'b0);
        cyc();

        // starvation: 4 loads then 1 store, repeating
        i_load_valid = 1'b1; i_load_addr = 32'h500;
        i_store_valid = 1'b1; i_store_addr = 32'h600; i_store_data = 32'h55;
        for (int k = 0; k < 10; k++) begin
            logic exp_store;
            exp_store = (k % 5 == 4);
            i_mem_resp_valid = 1'b0;
            mid(); check("starve_grant", o_load_grant, !exp_store); check("starve_idle", o_busy, 1'b0);
            cyc(); i_mem_resp_valid = 1'b1; i_mem_resp_data = 32'(k);
            mid(); check("starve_action", o_mem_action, exp_store);
            check("starve_ld_resp", o_load_resp_valid, !exp_store);
            check("starve_st_done", o_store_done, exp_store);
            cyc();
        end
        i_load_valid = 1'b0; i_store_valid = 1'b0; i_mem_resp_valid = 1'b0;
        mid(); check("starve_end_busy", o_busy, 1'b0);
        cyc();

        // flush while load outstanding, response two cycles later
        i_load_valid = 1'b1; i_load_addr = 32'h400;
        mid(); check("fl_grant", o_load_grant, 1'b1);
        cyc(); i_load_valid = 1'b0; i_flush = 1'b1;
        mid(); check("fl_c1_mem_valid", o_mem_valid, 1'b1);
        cyc(); i_flush = 1'b0;
        mid(); check("fl_c2_mem_valid", o_mem_valid, 1'b1); check("fl_c2_busy", o_busy, 1'b1);
        check("fl_c2_addr", o_mem_addr, 32'h400);
        cyc(); i_mem_resp_valid = 1'b1; i_mem_resp_data = 32'hCAFE;
        mid(); check("fl_c3_resp", o_load_resp_valid, 1'b0); check("fl_c3_mem_valid", o_mem_valid, 1'b1);
        check("fl_c3_data", o_load_resp_data, 32'h0);
        cyc(); i_mem_resp_valid = 1'b0;
        mid(); check("fl_c4_busy", o_busy, 1'b0);
        cyc();

        // flush and response in the same cycle
        i_load_valid = 1'b1; i_load_addr = 32'h440;
        mid(); check("flr_grant", o_load_grant, 1'b1);
        cyc(); i_load_valid = 1'b0; i_flush = 1'b1; i_mem_resp_valid = 1'b1; i_mem_resp_data = 32'h1;
        mid(); check("flr_resp", o_load_resp_valid, 1'b0);
        cyc(); i_flush = 1'b0; i_mem_resp_valid = 1'b0;
        mid(); check("flr_busy", o_busy, 1'b0);
        cyc();

        // flush in IDLE blocks a load grant
        i_load_valid = 1'b1; i_flush = 1'b1;
        mid(); check("fli_grant", o_load_grant, 1'b0);
        cyc(); i_load_valid = 1'b0; i_flush = 1'b0;
        mid(); check("fli_busy", o_busy, 1'b0);
        cyc();

        // response in IDLE is ignored
        i_mem_resp_valid = 1'b1; i_mem_resp_data = 32'hFFFF;
        mid(); check("idle_resp_ld", o_load_resp_valid, 1'b0); check("idle_resp_st", o_store_done, 1'b0);
        check("idle_resp_data", o_load_resp_data, 32'h0);
        cyc(); i_mem_resp_valid = 1'b0;
        mid(); check("idle_resp_busy", o_busy, 1'b0);
        cyc();

        // flush during store: store still completes
        i_store_valid = 1'b1; i_store_addr = 32'h240; i_store_data = 32'hAB; i_flush = 1'b1;
        mid(); check("fst_no_ld_grant", o_load_grant, 1'b0);
        cyc();
        mid(); check("fst_c1_mem_valid", o_mem_valid, 1'b1); check("fst_c1_action", o_mem_action, 1'b1);
        check("fst_c1_data", o_mem_data, 32'hAB);
        cyc(); i_mem_resp_valid = 1'b1;
        mid(); check("fst_done", o_store_done, 1'b1);
        cyc(); i_mem_resp_valid = 1'b0; i_store_valid = 1'b0; i_flush = 1'b0;
        mid(); check("fst_end_busy", o_busy, 1'b0);
        cyc();

        // async reset during STORE_BUSY, then a clean load
        i_store_valid = 1'b1; i_store_addr = 32'h700; i_store_data = 32'h99;
        cyc();
        mid(); check("ars_mem_valid", o_mem_valid, 1'b1); check("ars_action", o_mem_action, 1'b1);
        #1 rst = 1'b1;
        #1 check("ars_drop_valid", o_mem_valid, 1'b0); check("ars_busy", o_busy, 1'b0);
        check("ars_addr", o_mem_addr, 32'h0);
        i_store_valid = 1'b0;
        #1 rst = 1'b0; i_load_valid = 1'b1; i_load_addr = 32'h800;
        #1 check("ars_pre_edge_grant", o_load_grant, 1'b0);
        cyc();
        mid(); check("ars_ld_grant", o_load_grant, 1'b1);
        cyc(); i_load_valid = 1'b0; i_mem_resp_valid = 1'b1; i_mem_resp_data = 32'hBEEF;
        mid(); check("ars_ld_addr", o_mem_addr, 32'h800); check("ars_ld_action", o_mem_action, 1'b0);
        check("ars_ld_resp", o_load_resp_valid, 1'b1); check("ars_ld_data", o_load_resp_data, 32'hBEEF);
        cyc(); i_mem_resp_valid = 1'b0;
        mid(); check("ars_end_busy", o_busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dcache_port_arbiter.md
Name: dcache_port_arbiter

Overview:
Shares the single data-cache request port between the load path (memory stage) and the store-queue drain path (commit side). It picks one requester, holds the request stable until the cache responds, and routes the response back. Loads normally win. A starvation counter guarantees store drain progress, and a flush squashes only in-flight loads, because stores are already committed.

Parameters:
ADDR_W, 32, address width; must match package Address.
DATA_W, 32, data width; must match package Data.
MAX_LOAD_STREAK, 4, consecutive load grants allowed while a store waits; range 1..255.

Ports:
clk  in  1  clock; all state updates on posedge.
rst  in  1  asynchronous, active-high reset.
i_flush  in  1  hazard-controller flush.
i_load_valid  in  1  load request present.
i_load_addr  in  ADDR_W  load address.
o_load_grant  out  1  load accepted this cycle; the requester drops or advances.
o_load_resp_valid  out  1  load data valid; 1-cycle pulse.
o_load_resp_data  out  DATA_W  load data.
i_store_valid  in  1  store-queue head ready to write.
i_store_addr  in  ADDR_W  store address.
i_store_data  in  DATA_W  store data.
o_store_done  out  1  store written; 1-cycle pulse; the store queue pops its head.
o_mem_valid  out  1  cache request valid.
o_mem_action  out  1  0=READ, 1=WRITE.
o_mem_addr  out  ADDR_W  cache address; addr_next is driven equal by the wrapper.
o_mem_data  out  DATA_W  write data.
i_mem_resp_valid  in  1  cache response or completion.
i_mem_resp_data  in  DATA_W  cache read data.
o_busy  out  1  high in any non-IDLE state.

Behaviour:
- Reset (async, rst=1): state=IDLE, streak=0, request registers=0. All outputs are 0, and stay 0 until the first post-reset posedge. A reset mid-transaction abandons the transaction; the cache is reset by the same rst.
- States:
  - IDLE: grant decision, combinational on the current inputs.
  - LOAD_BUSY / STORE_BUSY: a transaction is outstanding.
  - LOAD_SQUASH: a flushed load is still outstanding.
- IDLE arbitration, evaluated in this order:
  - i_flush=1 → no load grant this cycle. A store may still be granted.
  - i_store_valid && (!i_load_valid || streak==MAX_LOAD_STREAK) → grant store, latch addr/data, go to STORE_BUSY, streak←0.
  - else i_load_valid → o_load_grant=1, latch addr, go to LOAD_BUSY. If i_store_valid, streak←streak+1 (saturating at MAX_LOAD_STREAK); else streak←0.
  - else stay in IDLE.
- o_mem_* is driven only from registered request state: o_mem_valid=1 in all BUSY/SQUASH states and 0 in IDLE. Address, data and action are held constant until i_mem_resp_valid.
- Latency: a grant at cycle N puts o_mem_valid high at N+1. The response at cycle M gives o_load_resp_valid or o_store_done in the same cycle M (combinational pass-through of i_mem_resp_data). State returns to IDLE at M+1. No new grant happens in cycle M, so there is one bubble between transactions.
- Flush:
  - LOAD_BUSY + i_flush → LOAD_SQUASH. o_mem_valid stays high.
  - On response in LOAD_SQUASH, o_load_resp_valid=0 and state goes to IDLE.
  - Flush and response in the same cycle while in LOAD_BUSY → the response is suppressed.
  - Flush has no effect on STORE_BUSY or IDLE store grants.
- i_mem_resp_valid while in IDLE is ignored.
- The store inputs must stay stable until o_store_done; the arbiter latches them anyway.

Optional Feature:
DCACHE_ARB_PERF_EN. When defined, three 32-bit wrapping counters are added:
- load grants;
- store grants;
- store-wait cycles, meaning cycles with i_store_valid=1 and no store grant while not in STORE_BUSY.

These are exposed on outputs o_perf_load_cnt, o_perf_store_cnt and o_perf_store_wait_cnt, cleared by rst and printed at debug_level()>=2 on each store grant. When undefined, the ports and logic are absent and the port list is exactly as above.

Decomposition:
- Package: arb_state_t enum (IDLE, LOAD_BUSY, STORE_BUSY, LOAD_SQUASH); mem_action_t (READ/WRITE); Address/Data typedefs; MAX_LOAD_STREAK default constant.
- Sub-module: arb_streak_counter, a saturating counter with inc/clr/sat outputs, used for starvation control.

Test Plan:
- Load only: i_load_valid=1, addr=0x100 at cycle 0; response data=0xDEAD at cycle 3 → o_mem_valid cycles 1-3 with action=READ and addr=0x100; o_load_resp_data=0xDEAD at cycle 3; IDLE at cycle 4.
- Simultaneous requests: load and store (addr 0x200, data 7) valid in IDLE with streak=0 → load granted first; store granted at the next IDLE; o_store_done pulses on its response.
- Starvation: loads and store continuously valid, MAX_LOAD_STREAK=4, single-cycle responses → exactly 4 load grants, then 1 store grant, with the pattern repeating.
- Flush in flight: load granted, i_flush at cycle 1, response at cycle 3 → o_load_resp_valid stays 0, o_mem_valid held through cycle 3, state IDLE at cycle 4.
- Flush during store: store granted, i_flush at cycle 1 → store completes and o_store_done=1 on the response.
- Async reset mid-STORE_BUSY: assert rst between edges → o_mem_valid drops immediately and o_busy=0; after release, a new load is granted normally.
